water_monitor_ctrl: RTL and testbench
=====================================

WATER_MONITOR_CTRL -- requirements
Module: water_monitor_ctrl

Interface
REQ-001 Parameter N_CH, 4, number of monitored channels (1..16) SHALL be supported.
REQ-002 Parameter LVL_W, 8, level and threshold width in bits.
REQ-003 Parameter PERSIST, 3, consecutive qualifying samples needed for any NORMAL/LOW/HIGH transition.
REQ-004 Parameter HYST, 2, hysteresis band applied on exit from LOW/HIGH.
REQ-005 Parameter ALARM_SAMP, 4, further consecutive over-high samples in HIGH before ALARM.
REQ-006 Parameter TICK_DIV, 50000, clocks per sample tick (>=2).
REQ-007 clk  in  1  single system clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 enable  in  1  monitoring enable, level-sensitive.
REQ-010 level_in  in  N_CH*LVL_W  unsigned level per channel; channel i occupies bits [i*LVL_W +: LVL_W].
REQ-011 th_low / th_high  in  LVL_W each  shared unsigned low/high thresholds.
REQ-012 ack  in  1  acknowledge button, synchronous level; only its rising edge acts.
REQ-013 state_out  out  3*N_CH  per-channel state code, channel i at [3*i +: 3].
REQ-014 alarm  out  N_CH  bit i high while channel i is in ALARM.
REQ-015 beep_en  out  1  high while any ALARM channel is unacknowledged.
REQ-016 alarm_ch  out  max(1,clog2(N_CH))  priority alarm channel index.
REQ-017 sample_tick  out  1  one-clock strobe marking each evaluation.
REQ-018 cfg_err  out  1  high while th_low >= th_high.

Function
REQ-019 Tick counter SHALL count 0..TICK_DIV-1 and assert sample_tick for exactly one clk when it wraps to 0; counter runs regardless of enable.
REQ-020 State codes SHALL be OFF=000, NORMAL=001, LOW=010, HIGH=011, ALARM=100; other codes unreachable.
REQ-021 Channel state and persistence counters SHALL change only on sample_tick, except for enable and ack effects below.
REQ-022 Per tick: "over" = level > th_high, "under" = level < th_low, "clr_hi" = level <= sat0(th_high-HYST), "clr_lo" = level >= satmax(th_low+HYST); arithmetic in LVL_W+1 bits, saturating at 0 and 2^LVL_W-1.
REQ-023 NORMAL: PERSIST consecutive "over" ticks -> HIGH; PERSIST consecutive "under" ticks -> LOW; any non-qualifying tick clears the count.
REQ-024 LOW: PERSIST consecutive "clr_lo" ticks -> NORMAL; levels between th_low and th_low+HYST hold LOW and clear the count.
REQ-025 HIGH: ALARM_SAMP consecutive "over" ticks -> ALARM (count restarts on entry to HIGH); PERSIST consecutive "clr_hi" ticks -> NORMAL.
REQ-026 ALARM SHALL latch; it leaves only to NORMAL on a single tick where the channel is acknowledged and "clr_hi" holds.
REQ-027 ack rising edge (registered, 1-clk detect) SHALL set the acked flag of every channel already in ALARM in that cycle; a channel entering ALARM in the same cycle is not acked.
REQ-028 Acked flag SHALL clear when the channel leaves ALARM; a later re-entry is unacked.
REQ-029 beep_en = OR over channels of (ALARM and not acked), registered, updating the clk after the causing event.
REQ-030 alarm_ch = lowest-index unacked ALARM channel; else lowest-index ALARM channel; else 0.
REQ-031 enable low: next clk all channels OFF, counters and acked flags cleared; enable high: OFF -> NORMAL on next tick.
REQ-032 cfg_err high: channel states and acked flags frozen, persistence counters cleared each tick; ack still honoured; normal evaluation resumes first tick after cfg_err falls.

Reset
REQ-033 rst_n low SHALL immediately force: tick counter 0, all states OFF, all counters 0, acked flags 0, ack edge register 0, state_out 0, alarm 0, beep_en 0, alarm_ch 0, sample_tick 0; cfg_err reflects inputs combinationally.
REQ-034 After rst_n rises with enable high, channels SHALL enter NORMAL at the first sample_tick, TICK_DIV clocks after release.

Verification (N_CH=4, LVL_W=8, TICK_DIV=4, other defaults, th_low=20, th_high=180)
REQ-035 ch1 level 50 -> 200: HIGH after 3rd tick, ALARM after 4 more ticks, alarm=0010, beep_en=1, alarm_ch=1.
REQ-036 ch2 level 200 for 2 ticks then 100: stays NORMAL (001), count cleared; level 10 for 3 ticks -> LOW.
REQ-037 ch0 in HIGH, level 179 for 5 ticks -> stays HIGH; level 178 for 3 ticks -> NORMAL.
REQ-038 ch1 ALARM, ack pulse -> beep_en 0 next clk, state still 100; ch3 then reaches ALARM -> beep_en 1, alarm_ch=3; ch1 level 100 -> NORMAL on next tick.
REQ-039 rst_n pulsed low mid-alarm -> all outputs 0 within same cycle; first sample_tick 4 clks after release, states 001.
REQ-040 th_low=100, th_high=90 with ch0 in HIGH -> cfg_err=1, state stays 011 for 10 ticks despite level changes; restoring thresholds resumes evaluation.

Source files
------------

// File: rtl/water_monitor_ctrl.sv
// Multi-channel water level monitor: per-channel NORMAL/LOW/HIGH/ALARM state machines
// evaluated on a divided sample tick, with persistence, hysteresis and acknowledged alarms.
module water_monitor_ctrl #(
  parameter int N_CH       = 4,
  parameter int LVL_W      = 8,
  parameter int PERSIST    = 3,
  parameter int HYST       = 2,
  parameter int ALARM_SAMP = 4,
  parameter int TICK_DIV   = 50000,
  localparam int AW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [N_CH*LVL_W-1:0]  level_in,
  input  logic [LVL_W-1:0]       th_low,
  input  logic [LVL_W-1:0]       th_high,
  input  logic                   ack,
  output logic [3*N_CH-1:0]      state_out,
  output logic [N_CH-1:0]        alarm,
  output logic                   beep_en,
  output logic [AW-1:0]          alarm_ch,
  output logic                   sample_tick,
  output logic                   cfg_err
);

  localparam int TW   = $clog2(TICK_DIV);
  localparam int MAXC = (PERSIST > ALARM_SAMP) ? PERSIST : ALARM_SAMP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [LVL_W:0] HYST_V = (LVL_W+1)'(HYST);

  typedef enum logic [2:0] {
    ST_OFF    = 3'b000,
    ST_NORMAL = 3'b001,
    ST_LOW    = 3'b010,
    ST_HIGH   = 3'b011,
    ST_ALARM  = 3'b100
  } ch_state_t;

  logic [TW-1:0]   tick_cnt;
  logic            tick_now;
  logic            ack_q;
  logic            ack_rise;
  logic            beep_nx;
  ch_state_t       state_q  [N_CH];
  ch_state_t       state_nx [N_CH];
  logic [CW-1:0]   hi_q  [N_CH];
  logic [CW-1:0]   hi_nx [N_CH];
  logic [CW-1:0]   lo_q  [N_CH];
  logic [CW-1:0]   lo_nx [N_CH];
  logic [N_CH-1:0] acked_q;
  logic [N_CH-1:0] acked_nx;
  logic [N_CH-1:0] over;
  logic [N_CH-1:0] under;
  logic [N_CH-1:0] clr_hi;
  logic [N_CH-1:0] clr_lo;
  logic [LVL_W:0]  hi_diff;
  logic [LVL_W:0]  lo_sum;
  logic [LVL_W-1:0] clr_hi_th;
  logic [LVL_W-1:0] clr_lo_th;

  assign cfg_err  = (th_low >= th_high);
  assign tick_now = (tick_cnt == TW'(TICK_DIV - 1));
  assign ack_rise = ack & ~ack_q;

  // Hysteresis thresholds saturate instead of wrapping
  always_comb begin
    hi_diff   = {1'b0, th_high} - HYST_V;
    lo_sum    = {1'b0, th_low} + HYST_V;
    clr_hi_th = hi_diff[LVL_W] ? '0 : hi_diff[LVL_W-1:0];
    clr_lo_th = lo_sum[LVL_W] ? '1 : lo_sum[LVL_W-1:0];
    for (int i = 0; i < N_CH; i++) begin
      over[i]   = level_in[i*LVL_W +: LVL_W] > th_high;
      under[i]  = level_in[i*LVL_W +: LVL_W] < th_low;
      clr_hi[i] = level_in[i*LVL_W +: LVL_W] <= clr_hi_th;
      clr_lo[i] = level_in[i*LVL_W +: LVL_W] >= clr_lo_th;
    end
  end

  always_comb begin
    beep_nx = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      state_nx[i] = state_q[i];
      hi_nx[i]    = hi_q[i];
      lo_nx[i]    = lo_q[i];
      acked_nx[i] = acked_q[i];
      if (!enable) begin
        state_nx[i] = ST_OFF;
        hi_nx[i]    = '0;
        lo_nx[i]    = '0;
        acked_nx[i] = 1'b0;
      end else begin
        // Only channels already latched in ALARM take the acknowledge
        if (ack_rise && state_q[i] == ST_ALARM)
          acked_nx[i] = 1'b1;
        if (tick_now) begin
          hi_nx[i] = '0;
          lo_nx[i] = '0;
          if (!cfg_err) begin
            case (state_q[i])
              ST_OFF: state_nx[i] = ST_NORMAL;
              ST_NORMAL: begin
                if (over[i]) begin
                  if (int'(hi_q[i]) + 1 >= PERSIST) state_nx[i] = ST_HIGH;
                  else hi_nx[i] = hi_q[i] + CW'(1);
                end else if (under[i]) begin
                  if (int'(lo_q[i]) + 1 >= PERSIST) state_nx[i] = ST_LOW;
                  else lo_nx[i] = lo_q[i] + CW'(1);
                end
              end
              ST_LOW: begin
                if (clr_lo[i]) begin
                  if (int'(lo_q[i]) + 1 >= PERSIST) state_nx[i] = ST_NORMAL;
                  else lo_nx[i] = lo_q[i] + CW'(1);
                end
              end
              ST_HIGH: begin
                if (over[i]) begin
                  if (int'(hi_q[i]) + 1 >= ALARM_SAMP) state_nx[i] = ST_ALARM;
                  else hi_nx[i] = hi_q[i] + CW'(1);
                end else if (clr_hi[i]) begin
                  if (int'(lo_q[i]) + 1 >= PERSIST) state_nx[i] = ST_NORMAL;
                  else lo_nx[i] = lo_q[i] + CW'(1);
                end
              end
              ST_ALARM: begin
                if (acked_q[i] && clr_hi[i]) begin
                  state_nx[i] = ST_NORMAL;
                  acked_nx[i] = 1'b0;
                end
              end
              default: state_nx[i] = ST_OFF;
            endcase
          end
        end
      end
      beep_nx = beep_nx | ((state_nx[i] == ST_ALARM) && !acked_nx[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt    <= '0;
      sample_tick <= 1'b0;
      ack_q       <= 1'b0;
      beep_en     <= 1'b0;
      acked_q     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_OFF;
        hi_q[i]    <= '0;
        lo_q[i]    <= '0;
      end
    end else begin
      tick_cnt    <= tick_now ? '0 : tick_cnt + TW'(1);
      sample_tick <= tick_now;
      ack_q       <= ack;
      beep_en     <= beep_nx;
      acked_q     <= acked_nx;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_nx[i];
        hi_q[i]    <= hi_nx[i];
        lo_q[i]    <= lo_nx[i];
      end
    end
  end

  // Unacknowledged alarms take priority when choosing the reported channel
  always_comb begin
    logic [AW-1:0] sel_any;
    logic [AW-1:0] sel_un;
    logic          found_un;
    sel_any  = '0;
    sel_un   = '0;
    found_un = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      state_out[3*i +: 3] = state_q[i];
      alarm[i]            = (state_q[i] == ST_ALARM);
      if (state_q[i] == ST_ALARM) begin
        sel_any = AW'(i);
        if (!acked_q[i]) begin
          sel_un   = AW'(i);
          found_un = 1'b1;
        end
      end
    end
    alarm_ch = found_un ? sel_un : sel_any;
  end

endmodule

// File: tb/tb_water_monitor_ctrl.sv
// Directed, table-driven bench for water_monitor_ctrl with a short sample period;
// multi-cycle corners (ack, reset, enable) are hand-written sequences.
module tb_water_monitor_ctrl;

  localparam int N_CH     = 4;
  localparam int LVL_W    = 8;
  localparam int TICK_DIV = 4;
  localparam int N_VEC    = 19;

  typedef struct {
    logic [31:0] levels;
    logic [7:0]  tl;
    logic [7:0]  th;
    int          ticks;
    logic [11:0] st;
    logic [3:0]  al;
    logic        bp;
    logic [1:0]  ach;
    logic        cfg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] level_in;
  logic [7:0]  th_low;
  logic [7:0]  th_high;
  logic        ack;
  logic [11:0] state_out;
  logic [3:0]  alarm;
  logic        beep_en;
  logic [1:0]  alarm_ch;
  logic        sample_tick;
  logic        cfg_err;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs [N_VEC];

  water_monitor_ctrl #(
    .N_CH(N_CH), .LVL_W(LVL_W), .PERSIST(3), .HYST(2), .ALARM_SAMP(4), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .level_in(level_in),
    .th_low(th_low), .th_high(th_high), .ack(ack), .state_out(state_out),
    .alarm(alarm), .beep_en(beep_en), .alarm_ch(alarm_ch),
    .sample_tick(sample_tick), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [11:0] st, input logic [3:0] al,
                          input logic bp, input logic [1:0] ach, input logic cfg);
    checkOutput({tag, "_state"}, 32'(state_out), 32'(st));
    checkOutput({tag, "_alarm"}, 32'(alarm), 32'(al));
    checkOutput({tag, "_beep"}, 32'(beep_en), 32'(bp));
    checkOutput({tag, "_alarm_ch"}, 32'(alarm_ch), 32'(ach));
    checkOutput({tag, "_cfg_err"}, 32'(cfg_err), 32'(cfg));
  endtask

  // Returns #1 after the clock edge that produced the n-th sample_tick
  task automatic advanceTicks(input int n);
    for (int k = 0; k < n; k++) begin
      int guard = 0;
      do begin
        @(posedge clk);
        #1;
        guard++;
      end while (!sample_tick && guard < 2 * TICK_DIV + 2);
      if (!sample_tick) begin
        checks++;
        failures++;
        $display("[TB] FAIL tick_timeout actual=%0d required=%0d", guard, TICK_DIV);
      end
    end
  endtask

  task automatic applyStimulus(input int i);
    level_in = vecs[i].levels;
    th_low   = vecs[i].tl;
    th_high  = vecs[i].th;
    advanceTicks(vecs[i].ticks);
    checkAll($sformatf("row%0d", i), vecs[i].st, vecs[i].al, vecs[i].bp, vecs[i].ach, vecs[i].cfg);
  endtask

  task automatic checkReleaseLatency(input string tag);
    int n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!sample_tick && n < 20);
    checkOutput({tag, "_tick_latency"}, 32'(n), 32'(TICK_DIV));
    checkOutput({tag, "_state"}, 32'(state_out), 32'h249);
  endtask

  initial begin
    // levels packed {ch3, ch2, ch1, ch0}
    vecs[0]  = '{{8'd50, 8'd200, 8'd200, 8'd50},  8'd20,  8'd180, 2, 12'h249, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{{8'd50, 8'd100, 8'd200, 8'd50},  8'd20,  8'd180, 1, 12'h259, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{{8'd50, 8'd200, 8'd200, 8'd50},  8'd20,  8'd180, 1, 12'h259, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{{8'd50, 8'd10,  8'd200, 8'd50},  8'd20,  8'd180, 2, 12'h259, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[4]  = '{{8'd50, 8'd10,  8'd200, 8'd50},  8'd20,  8'd180, 1, 12'h2A1, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[5]  = '{{8'd50, 8'd21,  8'd200, 8'd181}, 8'd20,  8'd180, 3, 12'h2A3, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[6]  = '{{8'd50, 8'd22,  8'd200, 8'd179}, 8'd20,  8'd180, 5, 12'h263, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[7]  = '{{8'd50, 8'd22,  8'd200, 8'd178}, 8'd20,  8'd180, 2, 12'h263, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[8]  = '{{8'd50, 8'd22,  8'd200, 8'd178}, 8'd20,  8'd180, 1, 12'h261, 4'b0010, 1'b1, 2'd1, 1'b0};
    vecs[9]  = '{{8'd250, 8'd22, 8'd200, 8'd178}, 8'd20,  8'd180, 3, 12'h661, 4'b0010, 1'b0, 2'd1, 1'b0};
    vecs[10] = '{{8'd250, 8'd22, 8'd200, 8'd178}, 8'd20,  8'd180, 4, 12'h861, 4'b1010, 1'b1, 2'd3, 1'b0};
    vecs[11] = '{{8'd250, 8'd22, 8'd100, 8'd178}, 8'd20,  8'd180, 1, 12'h849, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[12] = '{{8'd100, 8'd22, 8'd100, 8'd178}, 8'd20,  8'd180, 1, 12'h849, 4'b1000, 1'b1, 2'd3, 1'b0};
    vecs[13] = '{{8'd100, 8'd22, 8'd100, 8'd200}, 8'd20,  8'd180, 3, 12'h24B, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[14] = '{{8'd100, 8'd22, 8'd200, 8'd179}, 8'd20,  8'd180, 2, 12'h24B, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[15] = '{{8'd100, 8'd22, 8'd200, 8'd10},  8'd100, 8'd90,  5, 12'h24B, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[16] = '{{8'd100, 8'd22, 8'd200, 8'd250}, 8'd100, 8'd90,  5, 12'h24B, 4'b0000, 1'b0, 2'd0, 1'b1};
    vecs[17] = '{{8'd100, 8'd22, 8'd200, 8'd178}, 8'd20,  8'd180, 1, 12'h24B, 4'b0000, 1'b0, 2'd0, 1'b0};
    vecs[18] = '{{8'd100, 8'd22, 8'd200, 8'd178}, 8'd20,  8'd180, 2, 12'h259, 4'b0000, 1'b0, 2'd0, 1'b0};

    rst_n    = 1'b0;
    enable   = 1'b1;
    level_in = {8'd50, 8'd50, 8'd50, 8'd50};
    th_low   = 8'd20;
    th_high  = 8'd180;
    ack      = 1'b0;

    // Reset holds everything at zero even while the clock runs
    repeat (6) @(posedge clk);
    #1;
    checkAll("reset", 12'h000, 4'b0000, 1'b0, 2'd0, 1'b0);
    checkOutput("reset_tick", 32'(sample_tick), 32'd0);
    checkReleaseLatency("release");

    for (int i = 0; i <= 8; i++) applyStimulus(i);

    // Acknowledge ch1's alarm: beep drops next clock, alarm stays latched
    ack = 1'b1;
    @(posedge clk);
    #1;
    checkAll("ack", 12'h261, 4'b0010, 1'b0, 2'd1, 1'b0);
    @(posedge clk);
    #1;
    ack = 1'b0;

    for (int i = 9; i <= 12; i++) applyStimulus(i);

    // Asynchronous reset mid-alarm
    #2;
    rst_n = 1'b0;
    #1;
    checkAll("async_rst", 12'h000, 4'b0000, 1'b0, 2'd0, 1'b0);
    checkOutput("async_rst_tick", 32'(sample_tick), 32'd0);
    @(posedge clk);
    checkReleaseLatency("rerelease");

    for (int i = 13; i < N_VEC; i++) applyStimulus(i);

    // Enable low forces OFF on the next clock; re-enable returns to NORMAL on a tick
    enable = 1'b0;
    @(posedge clk);
    #1;
    checkAll("disable", 12'h000, 4'b0000, 1'b0, 2'd0, 1'b0);
    enable = 1'b1;
    advanceTicks(1);
    checkAll("reenable", 12'h249, 4'b0000, 1'b0, 2'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
